// File: rtl/shift_pipe.sv
// Pipelined logarithmic shifter (SLL/SRA/ROR/SRL) with valid/ready slots
// placed every REG_EVERY shift stages; tag, shamt, mode and sign ride along.

module shift_stage #(
  parameter int WIDTH = 16,
  parameter int SH    = 1
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] q_o
);
  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRA = 2'b01;
  localparam logic [1:0] M_ROR = 2'b10;

  always_comb begin
    q_o = d_i;
    if (en_i) begin
      case (mode_i)
        M_SLL:   q_o = {d_i[WIDTH-SH-1:0], {SH{1'b0}}};
        M_SRA:   q_o = {{SH{sign_i}}, d_i[WIDTH-1:SH]};
        M_ROR:   q_o = {d_i[SH-1:0], d_i[WIDTH-1:SH]};
        default: q_o = {{SH{1'b0}}, d_i[WIDTH-1:SH]};
      endcase
    end
  end
endmodule

module shift_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     In_valid,
  output logic                     In_ready,
  input  logic [WIDTH-1:0]         In,
  input  logic [$clog2(WIDTH)-1:0] Shamt,
  input  logic [1:0]               Mode,
  input  logic [TAG_W-1:0]         Tag,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [WIDTH-1:0]         Out,
  output logic [TAG_W-1:0]         Out_tag,
  output logic                     Out_zero
);
  localparam int NST = $clog2(WIDTH);
  localparam int L   = (NST + REG_EVERY - 1) / REG_EVERY;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [NST-1:0]   shamt;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic             sign;
  } slot_t;

  slot_t      up     [L];
  logic       up_vld [L];
  slot_t      slot_d [L];
  slot_t      slot_q [L];
  logic       vld_q  [L];
  logic [L:0] rdy;
  logic       zero_q;

  // Ready ripples back from the consumer; a slot is free if empty or draining.
  always_comb begin
    rdy[L] = Out_ready;
    for (int j = L - 1; j >= 0; j--) rdy[j] = !vld_q[j] || rdy[j+1];
  end

  // Stage k sits in the segment feeding slot k/REG_EVERY and is steered by
  // that segment's carried fields, never the live inputs once past slot 0.
  for (genvar k = 0; k < NST; k++) begin : g_stg
    localparam int SEG = k / REG_EVERY;
    logic [WIDTH-1:0] d, q;
    if (k % REG_EVERY == 0) begin : g_head
      assign d = up[SEG].data;
    end else begin : g_chain
      assign d = g_stg[k-1].q;
    end
    shift_stage #(.WIDTH(WIDTH), .SH(1 << k)) u_stage (
      .d_i    (d),
      .en_i   (up[SEG].shamt[k]),
      .mode_i (up[SEG].mode),
      .sign_i (up[SEG].sign),
      .q_o    (q)
    );
  end

  for (genvar j = 0; j < L; j++) begin : g_slot
    localparam int LAST = (((j + 1) * REG_EVERY < NST) ? (j + 1) * REG_EVERY : NST) - 1;
    if (j == 0) begin : g_src_in
      assign up[j]     = '{data: In, shamt: Shamt, mode: Mode, tag: Tag, sign: In[WIDTH-1]};
      assign up_vld[j] = In_valid;
    end else begin : g_src_slot
      assign up[j]     = slot_q[j-1];
      assign up_vld[j] = vld_q[j-1];
    end
    assign slot_d[j] = '{data: g_stg[LAST].q, shamt: up[j].shamt, mode: up[j].mode,
                         tag: up[j].tag, sign: up[j].sign};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[j]  <= 1'b0;
        slot_q[j] <= '0;
      end else if (rdy[j]) begin
        vld_q[j]  <= up_vld[j];
        slot_q[j] <= slot_d[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zero_q <= 1'b1;
    else if (rdy[L-1]) zero_q <= (slot_d[L-1].data == '0);
  end

  assign In_ready  = rdy[0];
  assign Out_valid = vld_q[L-1];
  assign Out       = slot_q[L-1].data;
  assign Out_tag   = slot_q[L-1].tag;
  assign Out_zero  = zero_q;
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined logarithmic shift unit for the execute stage. It supports four shift modes: logical left, arithmetic right, rotate right and logical right. The datapath is `log2(WIDTH)` shift stages, and each stage picks between the unshifted value and a shift by `2^k`. Pipeline registers are inserted every `REG_EVERY` stages. A valid/ready handshake lets the unit stall under back-pressure without losing or duplicating operations.

## Interface
- `WIDTH`, default 16: data width. Must be a power of 2, minimum 4.
- `REG_EVERY`, default 2: number of shift stages between pipeline registers. Legal range is 1..`log2(WIDTH)`.
- `TAG_W`, default 4: width of the sideband tag carried alongside each operation.
- `clk` (in, 1): clock. All state updates on the rising edge.
- `rst_n` (in, 1): reset, asynchronous assert, active-low.
- `In_valid` (in, 1): input operation is valid.
- `In_ready` (out, 1): unit accepts the input this cycle.
- `In` (in, `WIDTH`): operand.
- `Shamt` (in, `log2(WIDTH)`): shift amount.
- `Mode` (in, 2): operation select. 00 = SLL, 01 = SRA, 10 = ROR, 11 = SRL.
- `Tag` (in, `TAG_W`): opaque sideband, returned unchanged with the result.
- `Out_valid` (out, 1): result is valid.
- `Out_ready` (in, 1): consumer accepts the result.
- `Out` (out, `WIDTH`): result.
- `Out_tag` (out, `TAG_W`): tag of the result.
- `Out_zero` (out, 1): high when `Out` is zero. Registered with `Out`.

## Operation
- **Stage count:** `NST = log2(WIDTH)`. Pipeline depth is `L = ceil(NST / REG_EVERY)` register slots. Slot `j` follows stage `min((j+1)*REG_EVERY, NST) - 1`.
- **Shift stage `k`** (k = 0..`NST`-1) is controlled by `Shamt[k]`. If the bit is 0, the stage passes its input through. If the bit is 1, it shifts by `2^k`:
  - SLL: fill with zeros from the LSB.
  - SRL: fill with zeros from the MSB.
  - SRA: fill with the operand's original MSB. This sign bit is captured at input and carried through the slots.
  - ROR: bits shifted out of the LSB wrap into the MSB.
- **Carried fields:** `Shamt`, `Mode`, `Tag` and the sign bit travel with the data in every slot. Stages after a slot use the carried copies, never the live inputs.
- **Slot `j` state:** `valid_j`, data, and the carried fields.
  - `ready_j = !valid_j || ready_{j+1}`, with `ready_L = Out_ready`.
  - On a rising edge, if `ready_j` is high, slot `j` loads from upstream and `valid_j` takes the upstream valid.
  - If `ready_j` is low, slot `j` holds its contents.
- **Outputs:**
  - `In_ready = ready_0`. It is combinational from `Out_ready` through the chain. No combinational path from `In_valid` to `In_ready`.
  - `Out`, `Out_tag`, `Out_zero` and `Out_valid` come directly from the last slot.
- **Acceptance:** a transfer happens when `valid && ready` on an edge. Operations leave in acceptance order with their own tags. No drops, no duplicates.
- **Stalls:** while `Out_valid` is high and `Out_ready` is low, `Out` and `Out_tag` hold stable. Bubbles upstream of the stall are still filled.
- **Shift by zero:** `Shamt` = 0 returns `In` unchanged in every mode.

## Timing
- **Reset:** all `valid_j` are 0, so `Out_valid` = 0. `Out` = 0, `Out_tag` = 0, `Out_zero` = 1. `In_ready` is 1 whenever `rst_n` is high with the pipe empty.
- **Reset mid-operation:** asserting `rst_n` low clears every slot immediately. In-flight operations are discarded and nothing is emitted afterwards.
- **Latency:** an operation accepted at edge `t` produces `Out_valid` after edge `t + L - 1` when there is no stall (`L` = 2 for the defaults).
- **Throughput:** 1 operation per cycle when `Out_ready` is held high.
- **Simultaneous events:** on a full pipe with `Out_ready` = 1, the unit accepts a new input and emits a result on the same edge.
- **Capacity:** the pipe holds at most `L` operations. When it is full and `Out_ready` = 0, `In_ready` = 0.

## Test plan
Defaults apply: `WIDTH`=16, `REG_EVERY`=2, so `L`=2.

- **Modes, back-to-back, `Out_ready`=1.** Send these with tags 0..4:
  - SLL 0x00F1 by 4 → 0x0F10
  - SRL 0x8010 by 4 → 0x0801
  - SRA 0x8010 by 4 → 0xF801
  - ROR 0x1234 by 4 → 0x4123
  - SRA 0x8000 by 15 → 0xFFFF
  
  Required: results appear in order on consecutive cycles, first one 2 cycles after acceptance.
- **Boundaries.**
  - Any mode by 0 on 0xA5C3 → 0xA5C3.
  - SLL 0x0001 by 15 → 0x8000.
  - ROR 0x0001 by 15 → 0x0002.
  - SRL 0xFFFF by 15 → 0x0001.
  - SLL 0x8000 by 1 → 0x0000 with `Out_zero` = 1.
- **Back-pressure.** Hold `Out_ready` = 0 and stream 3 operations. Required: `In_ready` drops after 2 are accepted, and `Out`/`Out_tag` stay stable. Release `Out_ready`: all 3 drain in order, with no loss or duplication.
- **Bubble collapse.** Send op A and stall the output. Leave one idle cycle, then send op B. Required: B advances into the empty slot while A is held.
- **Reset mid-stream.** Fill the pipe, then pulse `rst_n` low between edges. Required: `Out_valid` goes to 0 immediately, `Out` = 0, and no stale results appear after reset is released.
- **Random scoreboard.** Run with `WIDTH`=32, `REG_EVERY`=1 and 10k random operations under random `Out_ready`. Compare against a reference model: every result must match and leave in order.
